// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and sizing helper for the iterative mul/div unit.
//   OP_*       : encodings of the op input (MULTU, MULT, DIVU, DIV)
//   state_t    : IDLE -> PREP -> ITER -> FIX -> IDLE
//   cnt_width  : bits needed to hold the iteration count XLEN/UNROLL
package muldiv_pkg;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    function automatic int cnt_width(input int xlen, input int unroll);
        return $clog2(xlen / unroll + 1);
    endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 step of shift-add multiply or restoring divide.
//   is_div  : 1 = restoring divide step, 0 = shift-add multiply step
//   operand : multiplicand (mul) or divisor magnitude (div)
//   acc_in  : 2*XLEN accumulator; mul {partial, multiplier}, div {remainder, dividend/quotient}
//   acc_out : accumulator after one step
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [XLEN-1:0]     operand,
    input  logic [2*XLEN-1:0]   acc_in,
    output logic [2*XLEN-1:0]   acc_out
);
    logic [XLEN:0] sum;
    logic [XLEN:0] part;
    logic [XLEN:0] diff;

    // Multiply: add multiplicand into the upper half when the low bit is set,
    // keeping the carry, then shift right.  Divide: shift the next dividend bit
    // into the remainder and subtract the divisor, restoring on borrow; the
    // quotient bit enters at the bottom as the dividend drains out the top.
    always_comb begin
        sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, operand};
        part    = acc_in[2*XLEN-1:XLEN-1];
        diff    = part - {1'b0, operand};
        acc_out = is_div ? (diff[XLEN] ? {part[XLEN-1:0], acc_in[XLEN-2:0], 1'b0}
                                       : {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1})
                         : (acc_in[0] ? {sum, acc_in[XLEN-1:1]}
                                      : {1'b0, acc_in[2*XLEN-1:1]});
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers.
//   clk, reset       : clock, synchronous active-low reset
//   start, op, a, b  : issue request (sampled in IDLE), op code, rs and rt operands
//   flush            : cancel any in-flight operation
//   hi_we, lo_we     : MTHI/MTLO writes of wdata; cancel any in-flight operation
//   busy             : state is not IDLE
//   done             : one-cycle pulse when hi/lo take a mul/div result
//   hi, lo           : HI/LO result registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int             CW    = cnt_width(XLEN, UNROLL);
    localparam logic [CW-1:0]  ITERS = CW'(XLEN / UNROLL);

    state_t             state;
    logic [1:0]         op_r;
    logic [XLEN-1:0]    a_r;
    logic [XLEN-1:0]    b_r;
    logic [XLEN-1:0]    operand;
    logic [2*XLEN-1:0]  acc;
    logic [CW-1:0]      cnt;
    logic               neg_q;
    logic               neg_r;
    logic               is_div;
    logic               sgn;
    logic               cancel;
    logic [XLEN-1:0]    mag_a;
    logic [XLEN-1:0]    mag_b;
    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    res_hi;
    logic [XLEN-1:0]    res_lo;
    logic [2*XLEN-1:0]  chain [UNROLL+1];

    // The accumulator ends up as {hi, lo} for both mul and div; only the sign
    // fix differs (whole 2*XLEN negate vs. independent quotient/remainder).
    always_comb begin
        is_div = op_r[1];
        sgn    = op_r[0];
        cancel = flush | hi_we | lo_we;
        mag_a  = (sgn && a_r[XLEN-1]) ? -a_r : a_r;
        mag_b  = (sgn && b_r[XLEN-1]) ? -b_r : b_r;
        prod   = neg_q ? -acc : acc;
        res_hi = is_div ? (neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN]) : prod[2*XLEN-1:XLEN];
        res_lo = is_div ? (neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0]) : prod[XLEN-1:0];
    end

    assign chain[0] = acc;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div (is_div),
            .operand(operand),
            .acc_in (chain[i]),
            .acc_out(chain[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
            if (cancel) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        op_r  <= op;
                        busy  <= 1'b1;
                        state <= PREP;
                    end
                    PREP: begin
                        cnt   <= ITERS;
                        neg_q <= sgn & (a_r[XLEN-1] ^ b_r[XLEN-1]);
                        neg_r <= sgn & a_r[XLEN-1];
                        if (is_div && b_r == '0) begin
                            // Divide-by-zero result is produced directly, unsigned.
                            acc   <= {a_r, {XLEN{1'b1}}};
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= FIX;
                        end else begin
                            acc     <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                            operand <= is_div ? mag_b : mag_a;
                            state   <= ITER;
                        end
                    end
                    ITER: begin
                        acc <= chain[UNROLL];
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) state <= FIX;
                    end
                    FIX: begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with HI/LO result registers for the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU over multiple cycles and exposes busy so the hazard logic can stall MFHI/MFLO and later mul/div issues. It replaces fixed-width single-cycle arithmetic with a width- and radix-parametrised engine that supports cancellation, early termination on divide-by-zero, and direct HI/LO writes.

Parameters:
XLEN, 32, operand width; hi and lo are each XLEN bits.
UNROLL, 1, iteration steps per cycle; legal values 1, 2, 4; XLEN must be divisible by UNROLL.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-low reset
start  in  1  issue request; sampled only in IDLE
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  in  XLEN  rs operand (dividend / multiplicand)
b  in  XLEN  rt operand (divisor / multiplier)
flush  in  1  cancel in-flight operation (exception/IRQ entry)
hi_we  in  1  MTHI write
lo_we  in  1  MTLO write
wdata  in  XLEN  MTHI/MTLO data
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse when hi/lo take a new mul/div result
hi  out  XLEN  HI register
lo  out  XLEN  LO register

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; hi=0, lo=0, busy=0, done=0. Reset takes effect mid-operation with no partial result written.
- States: IDLE -> PREP -> ITER -> FIX -> IDLE.
- IDLE: start=1 latches a, b and op, then moves to PREP. start is ignored outside IDLE.
- PREP: for signed ops, take operand magnitudes and record the result signs (quotient/product sign = a[XLEN-1]^b[XLEN-1]; remainder sign = a[XLEN-1]). Load the iteration counter with XLEN/UNROLL.
- PREP, DIV/DIVU with b==0: skip ITER, go to FIX, and produce hi=a, lo={XLEN{1}}.
- ITER: each cycle performs UNROLL radix-2 steps. Multiply uses shift-add into a 2*XLEN accumulator. Divide uses restoring shift-subtract. Leave ITER when the counter reaches 0.
- FIX: apply sign correction (two's-complement negate of the 2*XLEN product, or of quotient/remainder independently). Write hi/lo on the FIX->IDLE edge.
- Result mapping: mul gives hi=product[2XLEN-1:XLEN], lo=product[XLEN-1:0]. div gives lo=quotient, hi=remainder.
- DIV of the most negative value by -1: lo=most negative value, hi=0. This falls out of magnitude arithmetic; no special case.
- Latency: done is high for exactly one cycle, XLEN/UNROLL+2 edges after the edge that sampled start (34 with defaults). Divide-by-zero takes 2 edges. hi/lo change on the same edge that raises done.
- busy=1 from the edge after start is accepted until the edge that raises done, inclusive of FIX.
- flush=1: next state IDLE; hi/lo unchanged; no done. Takes priority over everything except reset.
- hi_we/lo_we:
  - Write wdata on the next edge in any state.
  - If busy, the in-flight operation is cancelled (as for flush).
  - In IDLE, a write has priority over start, and start is dropped in that cycle.
  - hi_we and lo_we together write both registers.
- Simultaneous flush and hi_we: the write is performed and the operation is cancelled.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- muldiv_pkg: op encoding constants (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), state enum (IDLE, PREP, ITER, FIX), and a counter-width function based on clog2(XLEN/UNROLL+1).
- Sub-module muldiv_step: one combinational radix-2 step (mul shift-add or div restoring subtract, selected by an is_div input), parametrised by XLEN. Instantiated UNROLL times in a chain.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly 34 edges after start; hi=0xFFFFFFFE, lo=0x00000001; busy low the cycle after.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Repeat with UNROLL=4 -> same result, done after 10 edges.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> done after 2 edges; hi=0x00001234, lo=0xFFFFFFFF.
- Start DIVU 100/7, assert flush at edge 10 -> busy low next cycle; no done; hi/lo keep prior values. A new start afterwards completes correctly (lo=14, hi=2).
- Start MULT, pull reset low at edge 5 -> hi=lo=0, busy=0. start held high in the same cycle as lo_we=1 (wdata=0xA5A5A5A5) -> lo=0xA5A5A5A5; no operation begins.
